// File: rtl/acq_frame_sequencer.sv
// rtl/acq_frame_sequencer.sv - frame-counted ADC capture sequencer for the ADC-to-UDP FIFO write side
module acq_frame_sequencer #(
  parameter int RST_CYCLES    = 8,
  parameter int SETTLE_CYCLES = 16,
  parameter int FRAME_LEN     = 1024,
  parameter int CNT_W         = 11,
  parameter int DRAIN_TIMEOUT = 65535
) (
  input  logic       clk_32,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] cfg_frames,
  input  logic       fifo_full,
  input  logic       fifo_empty_async,
  output logic       fifo_rst,
  output logic       en_adc,
  output logic       wr_en,
  output logic       busy,
  output logic       done,
  output logic       overflow,
  output logic       drain_timeout,
  output logic [7:0] frames_done
);

  // One shared timer covers the RESET, SETTLE and DRAIN waits; sized for the longest.
  localparam int TMR_W = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] RST_LAST    = TMR_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] DRAIN_LAST  = TMR_W'(DRAIN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(FRAME_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_SETTLE,
    S_ARM,
    S_CAPTURE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic [1:0]       empty_run_q, empty_run_d;
  logic [7:0]       cfg_q, cfg_d;
  logic [7:0]       frames_done_q, frames_done_d;
  logic             overflow_q, overflow_d;
  logic             drain_timeout_q, drain_timeout_d;
  logic             empty_meta_q, empty_meta_d;
  logic             empty_s_q, empty_s_d;
  logic             fifo_rst_q, fifo_rst_d;
  logic             en_adc_q, en_adc_d;
  logic             wr_en_q, wr_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Next-state, counters, sticky flags and registered outputs derived from the next state.
  always_comb begin
    state_d         = state_q;
    timer_d         = timer_q;
    sample_cnt_d    = sample_cnt_q;
    empty_run_d     = 2'd0;
    cfg_d           = cfg_q;
    frames_done_d   = frames_done_q;
    overflow_d      = overflow_q;
    drain_timeout_d = drain_timeout_q;
    empty_meta_d    = fifo_empty_async;
    empty_s_d       = empty_meta_q;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          cfg_d           = cfg_frames;
          frames_done_d   = 8'd0;
          overflow_d      = 1'b0;
          drain_timeout_d = 1'b0;
          timer_d         = '0;
          state_d         = S_RESET;
        end
      end
      S_RESET: begin
        if (timer_q == RST_LAST) begin
          timer_d = '0;
          state_d = S_SETTLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_SETTLE: begin
        if (timer_q == SETTLE_LAST) begin
          timer_d = '0;
          state_d = S_ARM;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_ARM: begin
        // One cycle so the ADC input register holds a real sample before the first write.
        sample_cnt_d = '0;
        state_d      = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (fifo_full) begin
          // Samples beyond full are lost anyway; cut the frame short and drain.
          overflow_d   = 1'b1;
          sample_cnt_d = '0;
          timer_d      = '0;
          state_d      = S_DRAIN;
        end else if (sample_cnt_q == SAMPLE_LAST) begin
          sample_cnt_d = '0;
          timer_d      = '0;
          state_d      = S_DRAIN;
        end else begin
          sample_cnt_d = sample_cnt_q + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (empty_s_q) begin
          empty_run_d = empty_run_q + 2'd1;
        end
        // Four consecutive synchronized empties filter a glitchy cross-domain flag.
        if (empty_s_q && (empty_run_q == 2'd3)) begin
          frames_done_d = frames_done_q + 8'd1;
          empty_run_d   = 2'd0;
          timer_d       = '0;
          if ((cfg_q == 8'd0) || (({1'b0, frames_done_q} + 9'd1) < {1'b0, cfg_q})) begin
            state_d = S_ARM;
          end else begin
            state_d = S_DONE;
          end
        end else if (timer_q == DRAIN_LAST) begin
          drain_timeout_d = 1'b1;
          timer_d         = '0;
          state_d         = S_IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d      = S_IDLE;
      timer_d      = '0;
      sample_cnt_d = '0;
      empty_run_d  = 2'd0;
    end

    fifo_rst_d = (state_d == S_RESET);
    en_adc_d   = (state_d inside {S_ARM, S_CAPTURE, S_DRAIN});
    wr_en_d    = (state_d == S_CAPTURE);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
  end

  // State, counters, empty synchronizer and output registers.
  always_ff @(posedge clk_32 or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      timer_q         <= '0;
      sample_cnt_q    <= '0;
      empty_run_q     <= 2'd0;
      cfg_q           <= 8'd0;
      frames_done_q   <= 8'd0;
      overflow_q      <= 1'b0;
      drain_timeout_q <= 1'b0;
      empty_meta_q    <= 1'b0;
      empty_s_q       <= 1'b0;
      fifo_rst_q      <= 1'b0;
      en_adc_q        <= 1'b0;
      wr_en_q         <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      sample_cnt_q    <= sample_cnt_d;
      empty_run_q     <= empty_run_d;
      cfg_q           <= cfg_d;
      frames_done_q   <= frames_done_d;
      overflow_q      <= overflow_d;
      drain_timeout_q <= drain_timeout_d;
      empty_meta_q    <= empty_meta_d;
      empty_s_q       <= empty_s_d;
      fifo_rst_q      <= fifo_rst_d;
      en_adc_q        <= en_adc_d;
      wr_en_q         <= wr_en_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
    end
  end

  assign fifo_rst      = fifo_rst_q;
  assign en_adc        = en_adc_q;
  assign wr_en         = wr_en_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign overflow      = overflow_q;
  assign drain_timeout = drain_timeout_q;
  assign frames_done   = frames_done_q;

endmodule

// File: tb/tb_acq_frame_sequencer.sv
// tb/tb_acq_frame_sequencer.sv - scoreboard bench for acq_frame_sequencer
module tb_acq_frame_sequencer;

  logic       clk_32 = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] cfg_frames;
  logic       fifo_full = 1'b0;
  logic       fifo_empty_async = 1'b0;
  logic       fifo_rst, en_adc, wr_en, busy, done, overflow, drain_timeout;
  logic [7:0] frames_done;

  acq_frame_sequencer dut (
    .clk_32           (clk_32),
    .rst_n            (rst_n),
    .start            (start),
    .abort            (abort),
    .cfg_frames       (cfg_frames),
    .fifo_full        (fifo_full),
    .fifo_empty_async (fifo_empty_async),
    .fifo_rst         (fifo_rst),
    .en_adc           (en_adc),
    .wr_en            (wr_en),
    .busy             (busy),
    .done             (done),
    .overflow         (overflow),
    .drain_timeout    (drain_timeout),
    .frames_done      (frames_done)
  );

  always #5 clk_32 = ~clk_32;

  int n_checks = 0;
  int n_fail   = 0;

  int exp_burst_q[$];
  int exp_rst_q[$];
  int exp_done_q[$];

  int cur_burst      = 0;
  int rst_len        = 0;
  int gap            = 0;
  int gap_valid      = 0;
  int drain_len      = 0;
  int last_drain_len = 0;
  int low_cnt        = 0;
  int full_at        = 0;
  bit drain_ok       = 1'b1;
  logic prev_wr = 1'b0, prev_rst = 1'b0, prev_en = 1'b0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Monitor: measures bursts/pulses on the falling edge, pops expectations, models the FIFO flags.
  always @(negedge clk_32) begin
    if (wr_en) begin
      if (!prev_wr && gap_valid != 0) begin
        check_eq("settle_arm_gap", gap, 17);
        gap_valid = 0;
      end
      cur_burst++;
      low_cnt   = 0;
      drain_len = 0;
    end else begin
      if (prev_wr) begin
        if (exp_burst_q.size() == 0) check_eq("burst_unexpected", exp_burst_q.size(), 1);
        else check_eq("burst_len", cur_burst, exp_burst_q.pop_front());
        cur_burst = 0;
      end
      if (low_cnt < 1000) low_cnt++;
      if (en_adc) drain_len++;
    end
    if (prev_en && !en_adc) last_drain_len = drain_len;

    if (fifo_rst) begin
      rst_len++;
    end else if (prev_rst) begin
      if (exp_rst_q.size() == 0) check_eq("fifo_rst_unexpected", exp_rst_q.size(), 1);
      else check_eq("fifo_rst_len", rst_len, exp_rst_q.pop_front());
      rst_len   = 0;
      gap       = 1;
      gap_valid = 1;
    end else if (gap_valid != 0) begin
      gap++;
    end

    if (done) begin
      if (exp_done_q.size() == 0) check_eq("done_unexpected", exp_done_q.size(), 1);
      else check_eq("frames_at_done", int'(frames_done), exp_done_q.pop_front());
    end

    fifo_full        = (full_at != 0) && wr_en && (cur_burst >= full_at);
    fifo_empty_async = drain_ok && !wr_en && (low_cnt >= 50);

    prev_wr  = wr_en;
    prev_rst = fifo_rst;
    prev_en  = en_adc;
  end

  task automatic do_start(input int cfg, input string tag);
    @(negedge clk_32); #1;
    cfg_frames = 8'(cfg);
    start      = 1'b1;
    @(negedge clk_32); #1;
    start = 1'b0;
    check_eq({tag, "_busy_on_start"}, int'(busy), 1);
    check_eq({tag, "_fifo_rst_on_start"}, int'(fifo_rst), 1);
    check_eq({tag, "_overflow_cleared"}, int'(overflow), 0);
    check_eq({tag, "_frames_cleared"}, int'(frames_done), 0);
  endtask

  task automatic wait_idle(input int limit, input string tag);
    int k = 0;
    while (busy && k < limit) begin
      @(negedge clk_32); #1;
      k++;
    end
    if (busy) check_eq({tag, "_idle_wait_expired"}, int'(busy), 0);
    repeat (2) @(negedge clk_32);
    #1;
  endtask

  task automatic wait_burst(input int n, input string tag);
    int k = 0;
    while (cur_burst != n && k < 3000) begin
      @(negedge clk_32); #1;
      k++;
    end
    if (cur_burst != n) check_eq({tag, "_burst_wait_expired"}, cur_burst, n);
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog: time limit reached, n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    cfg_frames = 8'd0;
    repeat (3) @(negedge clk_32);
    #1;
    check_eq("rst_fifo_rst", int'(fifo_rst), 0);
    check_eq("rst_en_adc", int'(en_adc), 0);
    check_eq("rst_wr_en", int'(wr_en), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_overflow", int'(overflow), 0);
    check_eq("rst_drain_timeout", int'(drain_timeout), 0);
    check_eq("rst_frames_done", int'(frames_done), 0);
    rst_n = 1'b1;
    @(negedge clk_32); #1;
    check_eq("idle_busy", int'(busy), 0);

    // Single frame.
    exp_rst_q.push_back(8);
    exp_burst_q.push_back(1024);
    exp_done_q.push_back(1);
    do_start(1, "t1");
    wait_burst(10, "t1");
    check_eq("t1_en_adc_capture", int'(en_adc), 1);
    check_eq("t1_fifo_rst_capture", int'(fifo_rst), 0);
    wait_idle(2000, "t1");
    check_eq("t1_frames_done", int'(frames_done), 1);
    check_eq("t1_overflow", int'(overflow), 0);
    check_eq("t1_drain_timeout", int'(drain_timeout), 0);

    // Three frames, one FIFO reset.
    exp_rst_q.push_back(8);
    repeat (3) exp_burst_q.push_back(1024);
    exp_done_q.push_back(3);
    do_start(3, "t2");
    wait_idle(5000, "t2");
    check_eq("t2_frames_done", int'(frames_done), 3);

    // Overflow at sample 500.
    full_at = 500;
    exp_rst_q.push_back(8);
    exp_burst_q.push_back(500);
    exp_done_q.push_back(1);
    do_start(1, "t3");
    wait_idle(2000, "t3");
    full_at = 0;
    check_eq("t3_overflow_after_done", int'(overflow), 1);
    check_eq("t3_frames_done", int'(frames_done), 1);
    check_eq("t3_drain_timeout", int'(drain_timeout), 0);

    // Abort at sample 200 in continuous mode.
    exp_rst_q.push_back(8);
    exp_burst_q.push_back(200);
    do_start(0, "t4");
    wait_burst(200, "t4");
    abort = 1'b1;
    @(negedge clk_32);
    @(negedge clk_32); #1;
    check_eq("t4_wr_en_after_abort", int'(wr_en), 0);
    check_eq("t4_en_adc_after_abort", int'(en_adc), 0);
    check_eq("t4_busy_after_abort", int'(busy), 0);
    abort = 1'b0;

    // Start while capturing is ignored.
    exp_rst_q.push_back(8);
    exp_burst_q.push_back(1024);
    exp_done_q.push_back(1);
    do_start(1, "t5");
    wait_burst(300, "t5");
    start = 1'b1;
    @(negedge clk_32); #1;
    start = 1'b0;
    check_eq("t5_wr_en_after_start", int'(wr_en), 1);
    wait_idle(2000, "t5");
    check_eq("t5_frames_done", int'(frames_done), 1);

    // Start and abort together in IDLE.
    @(negedge clk_32); #1;
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk_32); #1;
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk_32); #1;
    check_eq("t6_busy_start_abort", int'(busy), 0);
    check_eq("t6_fifo_rst_start_abort", int'(fifo_rst), 0);

    // Asynchronous reset mid-capture.
    exp_rst_q.push_back(8);
    exp_burst_q.push_back(100);
    do_start(2, "t7");
    wait_burst(100, "t7");
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("t7_wr_en_async_rst", int'(wr_en), 0);
    check_eq("t7_en_adc_async_rst", int'(en_adc), 0);
    check_eq("t7_busy_async_rst", int'(busy), 0);
    @(negedge clk_32); #1;
    rst_n = 1'b1;

    // Drain timeout with the FIFO never emptying.
    drain_ok = 1'b0;
    exp_rst_q.push_back(8);
    exp_burst_q.push_back(1024);
    do_start(1, "t8");
    wait_idle(70000, "t8");
    check_eq("t8_drain_timeout", int'(drain_timeout), 1);
    check_eq("t8_drain_cycles", last_drain_len, 65535);
    check_eq("t8_frames_done", int'(frames_done), 0);
    drain_ok = 1'b1;

    repeat (3) @(negedge clk_32);
    #1;
    check_eq("left_bursts", exp_burst_q.size(), 0);
    check_eq("left_fifo_rst", exp_rst_q.size(), 0);
    check_eq("left_done", exp_done_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
